// File: rtl/hex_segment_reader.sv
// ---------------------------------------------------------------------------
// hex_segment_reader
//   Reads back what the six active-low seven-segment buses (DE10-Lite layout)
//   are showing. All 48 segment bits are registered every clock, a settle
//   counter filters transients, and a stable pattern is decoded into six
//   4-bit digits plus per-display DP / blank / invalid flags. The update
//   output pulses for one cycle when a capture changes the held outputs.
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset_n   in   1   asynchronous active-low reset
//   en        in   1   1 = reader active, 0 = hold outputs and go idle
//   hex0..5   in   8   segment bytes, active-low, bit0=a .. bit6=g, bit7=DP
//   digits    out  24  digit i in [4i+3:4i], hex0 -> [3:0]
//   dp        out  6   bit i = DP lit on hexi
//   blank     out  6   bit i = hexi segments all off
//   invalid   out  6   bit i = hexi pattern not a hex glyph
//   valid     out  1   a capture has happened since reset
//   update    out  1   one-cycle pulse when captured outputs change
//   dbgState  out  2   current FSM state (IDLE=0 SETTLE=1 CAPTURE=2 STABLE=3)
//
// Handshake: there is no flow control. update is a single-cycle strobe that
// is high in the cycle right after the outputs were reloaded with a changed
// value; outputs are stable between strobes and may be sampled any time
// while valid is high.
// ---------------------------------------------------------------------------
module hex_segment_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [7:0]  hex0,
  input  logic [7:0]  hex1,
  input  logic [7:0]  hex2,
  input  logic [7:0]  hex3,
  input  logic [7:0]  hex4,
  input  logic [7:0]  hex5,
  output logic [23:0] digits,
  output logic [5:0]  dp,
  output logic [5:0]  blank,
  output logic [5:0]  invalid,
  output logic        valid,
  output logic        update,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    STABLE  = 2'd3
  } readerState;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  readerState        state;
  readerState        stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic              loadNow;

  logic [47:0] hexBus;
  logic [47:0] s;
  logic [47:0] prev;

  logic [23:0] decDigits;
  logic [5:0]  decDp;
  logic [5:0]  decBlank;
  logic [5:0]  decInvalid;
  logic        outChanged;

  assign hexBus   = {hex5, hex4, hex3, hex2, hex1, hex0};
  assign dbgState = state;

  // Segment pattern (active-low, g..a) to {invalid, blank, digit}.
  function automatic logic [5:0] decodeSeg(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b0;
    case (seg)
      7'h40: r[3:0] = 4'h0;
      7'h79: r[3:0] = 4'h1;
      7'h24: r[3:0] = 4'h2;
      7'h30: r[3:0] = 4'h3;
      7'h19: r[3:0] = 4'h4;
      7'h12: r[3:0] = 4'h5;
      7'h02: r[3:0] = 4'h6;
      7'h78: r[3:0] = 4'h7;
      7'h00: r[3:0] = 4'h8;
      7'h10: r[3:0] = 4'h9;
      7'h08: r[3:0] = 4'hA;
      7'h03: r[3:0] = 4'hB;
      7'h46: r[3:0] = 4'hC;
      7'h21: r[3:0] = 4'hD;
      7'h06: r[3:0] = 4'hE;
      7'h0E: r[3:0] = 4'hF;
      7'h7F: r[4]   = 1'b1;
      default: r[5] = 1'b1;
    endcase
    return r;
  endfunction

  // Input sampling stage. Reset value is "all segments off" so a blank
  // display does not look like a change right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s    <= '1;
      prev <= '1;
    end else begin
      s    <= hexBus;
      prev <= s;
    end
  end

  // Decode of the currently sampled bytes; DP never affects the digit.
  always_comb begin
    logic [5:0] d;
    decDigits  = '0;
    decDp      = '0;
    decBlank   = '0;
    decInvalid = '0;
    d          = '0;
    for (int i = 0; i < 6; i++) begin
      d                  = decodeSeg(s[8*i +: 7]);
      decDigits[4*i +: 4] = d[3:0];
      decBlank[i]        = d[4];
      decInvalid[i]      = d[5];
      decDp[i]           = ~s[8*i + 7];
    end
  end

  assign outChanged = (decDigits != digits) || (decDp != dp) ||
                      (decBlank != blank) || (decInvalid != invalid);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state logic. Outputs are loaded on the edge that enters CAPTURE,
  // so update is visible during the CAPTURE cycle itself.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    loadNow   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          stateNext = SETTLE;
          cntNext   = '0;
        end
      end
      SETTLE: begin
        if (!en) begin
          stateNext = IDLE;
        end else if (s != prev) begin
          cntNext = '0;
        end else if (cnt == CNT_LAST) begin
          stateNext = CAPTURE;
          loadNow   = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        stateNext = en ? STABLE : IDLE;
      end
      STABLE: begin
        if (!en) begin
          stateNext = IDLE;
        end else if (s != prev) begin
          stateNext = SETTLE;
          cntNext   = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Held outputs; they only change on a capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits  <= '0;
      dp      <= '0;
      blank   <= '0;
      invalid <= '0;
      valid   <= 1'b0;
      update  <= 1'b0;
    end else begin
      update <= 1'b0;
      if (loadNow) begin
        digits  <= decDigits;
        dp      <= decDp;
        blank   <= decBlank;
        invalid <= decInvalid;
        valid   <= 1'b1;
        update  <= !valid || outChanged;
      end
    end
  end

endmodule

// File: tb/tb_hex_segment_reader.sv
module tb_hex_segment_reader;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [23:0] digits;
  logic [5:0]  dp, blank, invalid;
  logic        valid, update;
  logic [1:0]  dbgState;

  int nCompared   = 0;
  int nMismatched = 0;

  hex_segment_reader #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .digits   (digits),
    .dp       (dp),
    .blank    (blank),
    .invalid  (invalid),
    .valid    (valid),
    .update   (update),
    .dbgState (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setHex(input logic [7:0] h5, input logic [7:0] h4, input logic [7:0] h3,
                        input logic [7:0] h2, input logic [7:0] h1, input logic [7:0] h0);
    hex5 = h5; hex4 = h4; hex3 = h3; hex2 = h2; hex1 = h1; hex0 = h0;
  endtask

  // Counts rising edges until update is seen; -1 if the budget runs out.
  task automatic waitUpdate(input int maxEdges, output int edges);
    int n;
    n = 0;
    edges = -1;
    while (n < maxEdges) begin
      tick();
      n++;
      if (update) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic expectNoUpdate(input string tag, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      tick();
      if (update) hits++;
    end
    checkVal(tag, hits, 0);
  endtask

  task automatic checkOutputs(input string tag, input logic [23:0] eDig, input logic [5:0] eDp,
                              input logic [5:0] eBlank, input logic [5:0] eInv);
    checkVal({tag, "_digits"}, {8'h0, digits}, {8'h0, eDig});
    checkVal({tag, "_dp"}, {26'h0, dp}, {26'h0, eDp});
    checkVal({tag, "_blank"}, {26'h0, blank}, {26'h0, eBlank});
    checkVal({tag, "_invalid"}, {26'h0, invalid}, {26'h0, eInv});
  endtask

  initial begin
    int lat;
    reset_n = 1'b1;
    en      = 1'b0;
    setHex(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // 1: async reset between edges, then idle with en low
    #3 reset_n = 1'b0;
    #1;
    checkOutputs("rst", 24'h0, 6'h0, 6'h0, 6'h0);
    checkVal("rst_valid", valid, 0);
    checkVal("rst_update", update, 0);
    checkVal("rst_state", dbgState, 0);
    repeat (2) tick();
    #3 reset_n = 1'b1;
    setHex(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    expectNoUpdate("idle_no_update", 10);
    checkVal("idle_valid", valid, 0);
    checkVal("idle_digits", digits, 0);

    // 2: first capture, latency from the edge that samples the new bytes
    en = 1'b1;
    setHex(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hC0);
    waitUpdate(20, lat);
    checkVal("first_latency", lat, 6);
    checkOutputs("first", 24'h123450, 6'h0, 6'h0, 6'h0);
    checkVal("first_valid", valid, 1);
    tick();
    checkVal("pulse_width", update, 0);

    // 3: 3-sample glitch on hex0 is filtered, then a held change captures
    hex0 = 8'hF9;
    repeat (3) tick();
    hex0 = 8'hC0;
    expectNoUpdate("glitch_no_update", 12);
    checkVal("glitch_digits", digits, 24'h123450);
    hex0 = 8'hF9;
    waitUpdate(20, lat);
    checkVal("change_latency", lat, 6);
    checkVal("change_digits", digits, 24'h123451);

    // 4: flags. 7E is not a glyph (invalid, DP lit), FF blank, 40 with DP lit
    setHex(8'hF9, 8'h7E, 8'hFF, 8'hFF, 8'h40, 8'hF9);
    waitUpdate(20, lat);
    checkVal("flagsA_latency", lat, 6);
    checkOutputs("flagsA", 24'h100001, 6'b010010, 6'b001100, 6'b010000);
    // 00 is an 8 with DP; 7F is blank with DP lit
    setHex(8'hF9, 8'h00, 8'h7F, 8'hFF, 8'h40, 8'hF9);
    waitUpdate(20, lat);
    checkOutputs("flagsB", 24'h180001, 6'b011010, 6'b001100, 6'b000000);
    // letters A..F
    setHex(8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E);
    waitUpdate(20, lat);
    checkOutputs("letters", 24'hABCDEF, 6'h0, 6'h0, 6'h0);
    setHex(8'h82, 8'hF8, 8'h80, 8'h90, 8'hC0, 8'hF9);
    waitUpdate(20, lat);
    checkOutputs("digits6789", 24'h678901, 6'h0, 6'h0, 6'h0);

    // 5: 2-cycle excursion back to the held value: capture but no pulse
    hex0 = 8'h86;
    repeat (2) tick();
    hex0 = 8'hF9;
    expectNoUpdate("resettle_no_update", 14);
    checkVal("resettle_digits", digits, 24'h678901);
    checkVal("resettle_valid", valid, 1);

    // en low holds outputs; re-enable captures from IDLE in 5 edges
    en = 1'b0;
    setHex(8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E);
    expectNoUpdate("disabled_no_update", 10);
    checkVal("disabled_digits", digits, 24'h678901);
    checkVal("disabled_state", dbgState, 0);
    en = 1'b1;
    waitUpdate(20, lat);
    checkVal("reenable_latency", lat, 5);
    checkVal("reenable_digits", digits, 24'hABCDEF);

    // 6: reset while settling, then a fresh capture pulses update
    setHex(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hC0);
    repeat (2) tick();
    checkVal("mid_settle_state", dbgState, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutputs("settle_rst", 24'h0, 6'h0, 6'h0, 6'h0);
    checkVal("settle_rst_valid", valid, 0);
    checkVal("settle_rst_state", dbgState, 0);
    #2 reset_n = 1'b1;
    waitUpdate(20, lat);
    checkVal("post_rst_latency", lat, 6);
    checkVal("post_rst_digits", digits, 24'h123450);
    checkVal("post_rst_valid", valid, 1);

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
